// File: rtl/v7458_pkg.sv
// Shared definitions for the 7458 dual AND-OR gate self-test block.
//   NUM_PAT : number of exhaustive input patterns (2^PAT_W)
//   PAT_W   : stimulus width (a..j)
//   CNT_W   : error counter width, wide enough to hold NUM_PAT
//   state_t : self-test sequencer states
package v7458_pkg;

  localparam int NUM_PAT = 1024;
  localparam int PAT_W   = 10;
  localparam int CNT_W   = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/v7458_model.sv
// Reference behaviour of the dual AND-OR gate.
//   i_pat : pattern, bit9..bit0 = a,b,c,d,e,f,g,h,i,j
//   o_m   : expected (a&b&c)|(d&e&f)
//   o_n   : expected (g&h)|(i&j)
module v7458_model
  import v7458_pkg::*;
(
  input  logic [PAT_W-1:0] i_pat,
  output logic             o_m,
  output logic             o_n
);

  assign o_m = (i_pat[9] & i_pat[8] & i_pat[7]) | (i_pat[6] & i_pat[5] & i_pat[4]);
  assign o_n = (i_pat[3] & i_pat[2]) | (i_pat[1] & i_pat[0]);

endmodule

// File: rtl/v7458_selftest.sv
// Exhaustive self-test sequencer for a 7458 dual AND-OR gate.
// Each pattern is driven for one cycle, left to settle for SETTLE cycles,
// then the gate outputs are compared against the reference model.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request a full run (honoured only when idle or done)
//   pat_o         : stimulus to the gate
//   m_i, n_i      : gate outputs under test
//   busy, done    : run in progress / run complete
//   pass          : run complete with no failing patterns
//   err_cnt       : failing pattern count
//   first_err_pat : first failing pattern (0 if none)
module v7458_selftest
  import v7458_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [PAT_W-1:0] pat_o,
  input  logic             m_i,
  input  logic             n_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [PAT_W-1:0] first_err_pat
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_settle_cnt;
  logic [PAT_W-1:0] r_pat;
  logic [CNT_W-1:0] r_err_cnt;
  logic [PAT_W-1:0] r_first_err;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             w_exp_m;
  logic             w_exp_n;
  logic             w_fail;
  logic             w_last_pat;
  logic             w_settle_end;

  v7458_model u_model (
    .i_pat (r_pat),
    .o_m   (w_exp_m),
    .o_n   (w_exp_n)
  );

  assign w_last_pat   = &r_pat;
  assign w_settle_end = (r_settle_cnt == 4'(SETTLE - 1));
  // One failure per pattern, regardless of how many outputs mismatch.
  assign w_fail = (r_state == ST_SAMPLE) && ((m_i != w_exp_m) || (n_i != w_exp_n));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_DRIVE;
      ST_DRIVE:         w_state_nxt = ST_SETTLE;
      ST_SETTLE:        if (w_settle_end) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE:        w_state_nxt = w_last_pat ? ST_DONE : ST_DRIVE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle_cnt <= '0;
      r_pat        <= '0;
      r_err_cnt    <= '0;
      r_first_err  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_pat       <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        ST_DRIVE: begin
          r_settle_cnt <= '0;
        end
        ST_SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 4'd1;
        end
        ST_SAMPLE: begin
          if (w_fail) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
            if (r_err_cnt == '0) r_first_err <= r_pat;
          end
          if (w_last_pat) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            // Include the final pattern's result, which is not yet in r_err_cnt.
            r_pass <= (r_err_cnt == '0) && !w_fail;
          end else begin
            r_pat <= r_pat + PAT_W'(1);
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign pat_o         = r_pat;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_cnt       = r_err_cnt;
  assign first_err_pat = r_first_err;

endmodule

// File: tb/tb_v7458_selftest.sv
module tb_v7458_selftest;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start3;
  logic [9:0]  pat1, pat3;
  logic        m1, n1, m3, n3;
  logic        busy1, done1, pass1, busy3, done3, pass3;
  logic [10:0] err1, err3;
  logic [9:0]  first1, first3;
  int          fault;
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  always #5 clk = ~clk;

  // Bench gate model with optional stuck-at faults on dut1's inputs.
  assign m1 = (fault == 1) ? 1'b0 : ((pat1[9] & pat1[8] & pat1[7]) | (pat1[6] & pat1[5] & pat1[4]));
  assign n1 = (fault == 2) ? 1'b1 : ((pat1[3] & pat1[2]) | (pat1[1] & pat1[0]));
  assign m3 = (pat3[9] & pat3[8] & pat3[7]) | (pat3[6] & pat3[5] & pat3[4]);
  assign n3 = (pat3[3] & pat3[2]) | (pat3[1] & pat3[0]);

  v7458_selftest #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pat_o(pat1), .m_i(m1), .n_i(n1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_pat(first1)
  );

  v7458_selftest #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .pat_o(pat3), .m_i(m3), .n_i(n3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .first_err_pat(first3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start on dut1, optionally re-pulse it at cycle 'mid', and count
  // cycles from the start edge until done is seen.
  task automatic run1(input int mid, output int ncyc);
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    chk("start_busy", busy1, 1);
    chk("start_done", done1, 0);
    chk("start_err", err1, 0);
    chk("start_pat", pat1, 0);
    ncyc = 0;
    while (!done1 && ncyc < 20000) begin
      start1 = (ncyc == mid);
      tick(1);
      ncyc++;
    end
    start1 = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    fault  = 0;
    tick(2);
    chk("rst_pat", pat1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_err", err1, 0);
    chk("rst_first", first1, 0);
    rst = 1'b0;
    tick(3);
    chk("idle_busy", busy1, 0);
    chk("idle_done", done1, 0);

    // Clean run, SETTLE=1
    run1(-1, cyc);
    chk("clean_cycles", cyc, 3072);
    chk("clean_err", err1, 0);
    chk("clean_pass", pass1, 1);
    chk("clean_first", first1, 0);
    chk("clean_busy", busy1, 0);
    chk("clean_pat", pat1, 10'h3FF);
    tick(2);
    chk("clean_hold_done", done1, 1);

    // m stuck at 0, started from DONE
    fault = 1;
    run1(-1, cyc);
    chk("m0_cycles", cyc, 3072);
    chk("m0_err", err1, 240);
    chk("m0_first", first1, 10'h070);
    chk("m0_pass", pass1, 0);

    // n stuck at 1
    fault = 2;
    run1(-1, cyc);
    chk("n1_err", err1, 576);
    chk("n1_first", first1, 10'h000);
    chk("n1_pass", pass1, 0);

    // Reset mid-run
    run1(-1, cyc);
    fault = 2;
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    tick(99);
    chk("mid_err_nonzero", (err1 != 0), 1);
    chk("mid_busy", busy1, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy1, 0);
    chk("arst_pat", pat1, 0);
    chk("arst_err", err1, 0);
    chk("arst_done", done1, 0);
    chk("arst_first", first1, 0);
    tick(1);
    rst = 1'b0;
    tick(3);
    chk("arst_idle", busy1, 0);
    fault = 0;
    run1(-1, cyc);
    chk("after_rst_cycles", cyc, 3072);
    chk("after_rst_err", err1, 0);
    chk("after_rst_pass", pass1, 1);

    // Extra start while busy is ignored
    run1(500, cyc);
    chk("restart_cycles", cyc, 3072);
    chk("restart_pass", pass1, 1);
    chk("restart_err", err1, 0);

    // SETTLE=3 instance
    start3 = 1'b1;
    tick(1);
    start3 = 1'b0;
    chk("s3_busy", busy3, 1);
    cyc = 0;
    while (!done3 && cyc < 20000) begin
      tick(1);
      cyc++;
    end
    chk("s3_cycles", cyc, 5120);
    chk("s3_pass", pass3, 1);
    chk("s3_err", err3, 0);
    chk("s3_first", first3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
